// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, debug load port and fetch outputs.
interface instruction_fetch_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              I_PC_WRITE;
   logic [1:0]        I_PC_SRC;
   logic [31:0]       I_BRANCH_TARGET;
   logic [31:0]       I_JUMP_TARGET;
   logic              I_LOAD_EN;
   logic [ADDR_W-1:0] I_LOAD_ADDR;
   logic [31:0]       I_LOAD_DATA;
   logic [31:0]       O_PC;
   logic [31:0]       O_PC_PLUS4;
   logic [31:0]       O_INSTRUCTION;
   logic              O_HALTED;

   // Pipeline/debug side: drives controls, observes fetch results
   modport master (
      output I_PC_WRITE, I_PC_SRC, I_BRANCH_TARGET, I_JUMP_TARGET,
             I_LOAD_EN, I_LOAD_ADDR, I_LOAD_DATA,
      input  O_PC, O_PC_PLUS4, O_INSTRUCTION, O_HALTED
   );

   // Fetch stage side
   modport slave (
      input  I_PC_WRITE, I_PC_SRC, I_BRANCH_TARGET, I_JUMP_TARGET,
             I_LOAD_EN, I_LOAD_ADDR, I_LOAD_DATA,
      output O_PC, O_PC_PLUS4, O_INSTRUCTION, O_HALTED
   );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: PC register, instruction memory with debug
// load port, next-PC selection under hazard stall.
// Optional halt-word detection is enabled by defining IF_HALT_DETECT_EN.
module instruction_fetch #(
   parameter int unsigned MEM_DEPTH = 256,
   parameter int unsigned ADDR_W    = 8
) (
   input logic               CLK,
   input logic               RESET,
   instruction_fetch_if.slave bus
);

   localparam int unsigned RANGE_LSB  = ADDR_W + 2;
   localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
   localparam logic [1:0]  SRC_BRANCH = 2'b01;
   localparam logic [1:0]  SRC_JUMP   = 2'b10;

   logic [31:0] mem_q [MEM_DEPTH];
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] rd_word;
   logic        in_range;
   logic        halted_q;
   logic        halt_hit;
   logic        suppress;

   // PC arithmetic and range check; PC above the memory window reads as 0
   assign pc_plus4 = pc_q + 32'd4;
   assign in_range = (pc_q >> RANGE_LSB) == 32'd0;
   assign rd_word  = in_range ? mem_q[pc_q[ADDR_W+1:2]] : 32'd0;

`ifdef IF_HALT_DETECT_EN
   logic halted_d;

   // Halt word seen at the current PC while fetching normally
   assign halt_hit = !bus.I_LOAD_EN && !halted_q && (rd_word == HALT_WORD);

   // Halt flag: set on halt word, cleared by any load cycle
   always_comb begin
      halted_d = halted_q;
      if (bus.I_LOAD_EN) begin
         halted_d = 1'b0;
      end else if (halt_hit) begin
         halted_d = 1'b1;
      end
   end

   // Halt flag register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end
`else
   assign halt_hit = 1'b0;
   assign halted_q = 1'b0;
`endif

   // Next PC: load, halt and stall all hold; otherwise select by source
   always_comb begin
      pc_d = pc_q;
      if (!bus.I_LOAD_EN && !halted_q && !halt_hit && bus.I_PC_WRITE) begin
         case (bus.I_PC_SRC)
            SRC_BRANCH: pc_d = bus.I_BRANCH_TARGET & ALIGN_MASK;
            SRC_JUMP:   pc_d = bus.I_JUMP_TARGET & ALIGN_MASK;
            default:    pc_d = pc_plus4;
         endcase
      end
   end

   // PC register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc_q <= 32'd0;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Instruction memory write port; contents survive reset
   always_ff @(posedge CLK) begin
      if (bus.I_LOAD_EN) begin
         mem_q[bus.I_LOAD_ADDR] <= bus.I_LOAD_DATA;
      end
   end

   // Output NOP while loading, halted, out of range, or on the halt word
   assign suppress = bus.I_LOAD_EN || halted_q || !in_range || halt_hit;

   assign bus.O_PC          = pc_q;
   assign bus.O_PC_PLUS4    = pc_plus4;
   assign bus.O_INSTRUCTION = suppress ? 32'd0 : rd_word;
   assign bus.O_HALTED      = halted_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage of the 5-stage MIPS pipeline: holds the program counter, reads the instruction memory, and selects the next PC (sequential, branch, jump) under hazard-unit stall control. Its outputs feed the IF/ID pipeline register directly: `O_INSTRUCTION` drives the register's instruction input and `O_PC_PLUS4` drives its PC input. It also provides a debug load port for programming instruction memory, and optional halt-instruction detection.

## Interface
- `MEM_DEPTH`, default 256: instruction memory depth in 32-bit words; must be a power of two.
- `ADDR_W`, default 8: word-address width, equal to log2(`MEM_DEPTH`).
- `CLK` in 1: clock, rising-edge active.
- `RESET` in 1: asynchronous, active-high.
- `I_PC_WRITE` in 1: from the hazard unit. 1 = PC may update; 0 = stall, PC holds.
- `I_PC_SRC` in 2: next-PC select.
  - 00 = PC+4
  - 01 = branch target
  - 10 = jump target
  - 11 = reserved; treated as 00
- `I_BRANCH_TARGET` in 32: branch target computed in ID.
- `I_JUMP_TARGET` in 32: j/jal/jr target computed in ID.
- `I_LOAD_EN` in 1: debug memory write strobe.
- `I_LOAD_ADDR` in ADDR_W: debug word address.
- `I_LOAD_DATA` in 32: debug write data.
- `O_PC` out 32: current PC register.
- `O_PC_PLUS4` out 32: `O_PC` + 4, mod 2^32.
- `O_INSTRUCTION` out 32: fetched instruction word, or 0 (NOP) when suppressed.
- `O_HALTED` out 1: halt flag.

## Operation
- **PC register**
  - Reset value 0x0000_0000.
  - Bits [1:0] are always 0; the low two bits of any selected target are forced to 0 before loading.
- **Next-PC priority, highest first:**
  1. `RESET`
  2. `I_LOAD_EN`: hold
  3. halted: hold
  4. `I_PC_WRITE`=0: hold
  5. `I_PC_SRC` select
- **Instruction memory read**
  - Asynchronous read of `mem[O_PC[ADDR_W+1:2]]`.
  - A PC with any bit above `ADDR_W+1` set is out of range and reads 0.
- **`O_INSTRUCTION` suppression:** forced to 0 while `I_LOAD_EN`=1, while halted, or when the PC is out of range.
- **Memory write**
  - Synchronous on the `CLK` rising edge when `I_LOAD_EN`=1.
  - Writes `mem[I_LOAD_ADDR]` <= `I_LOAD_DATA`.
  - Memory contents are not cleared by `RESET`.
- **Outputs under load:** `O_PC` and `O_PC_PLUS4` remain valid, but the PC does not advance while loading.
- **Stall and redirect:** when `I_PC_WRITE`=0, `I_PC_SRC` and the target inputs are ignored. A redirect requested during a stall is lost; the hazard unit re-presents it.

## Timing
- Fetch latency is zero cycles: `O_INSTRUCTION`, `O_PC` and `O_PC_PLUS4` are combinational from the PC register and memory.
- The PC updates on the rising edge at which the next-PC select is sampled. The new instruction is visible in the same cycle after that edge.
- **Redirect:** a branch or jump sampled at edge N places the target in `O_PC` after edge N. The wrong-path instruction fetched in the preceding cycle is removed by the IF/ID flush, which this block does not generate.
- **Asynchronous reset:** `RESET` asserted at any time drives `O_PC`=0 and `O_HALTED`=0 immediately, including in the middle of a load sequence. Memory writes already completed are retained.
- **Load timing:** a write at edge N is readable combinationally after edge N. The first fetch after `I_LOAD_EN` deasserts uses the held PC.
- **PC wrap:** PC 0xFFFF_FFFC + 4 wraps to 0x0000_0000.

## Configuration
- **Macro:** `IF_HALT_DETECT_EN`.
- **Defined:**
  - When `I_LOAD_EN`=0, not halted, and the in-range memory word at the PC equals 0xFFFF_FFFF, `O_HALTED` sets at the next rising edge. This happens regardless of `I_PC_WRITE`.
  - The PC freezes at the halt word's address.
  - The halt word itself is output as 0, so it never enters IF/ID.
  - `O_HALTED` clears on `RESET`, or at the first rising edge with `I_LOAD_EN`=1.
- **Not defined:**
  - 0xFFFF_FFFF is passed through as an ordinary word.
  - `O_HALTED` is tied to 0.
  - No halt register is implemented.

## Test plan
- **Reset and sequential fetch:** load mem[0..3] = 0x11,0x22,0x33,0x44 via the load port, then pulse `RESET` and hold `I_PC_WRITE`=1, `I_PC_SRC`=00.
  - Required: `O_PC` = 0,4,8,12 and `O_INSTRUCTION` = 0x11,0x22,0x33,0x44 on successive cycles.
  - Required: `O_PC_PLUS4` = `O_PC`+4 throughout.
- **Stall:** at PC=8, drop `I_PC_WRITE` for 3 cycles with `I_PC_SRC`=01 and `I_BRANCH_TARGET`=0x40.
  - Required: PC stays at 8 and `O_INSTRUCTION` stays 0x33.
  - Required: after release, PC=12 (the redirect was ignored while stalled).
- **Redirects:**
  - `I_PC_SRC`=01, `I_BRANCH_TARGET`=0x0000_0013: next PC = 0x10.
  - `I_PC_SRC`=10, `I_JUMP_TARGET`=0x4: next PC = 0x4.
  - `I_PC_SRC`=11: next PC = PC+4.
- **Load during fetch and out of range:**
  - Assert `I_LOAD_EN` at PC=4: `O_INSTRUCTION`=0 and PC held while loading; the written word is readable the cycle after the write.
  - Jump to 0x400 (`MEM_DEPTH`=256): `O_INSTRUCTION`=0.
- **Halt (macro defined):** mem[2] = 0xFFFF_FFFF, run from reset.
  - Required: `O_HALTED` rises after the edge with PC=8; PC stays at 8 and `O_INSTRUCTION`=0 for 10+ cycles.
  - Required: a one-cycle `I_LOAD_EN` clears `O_HALTED`.
  - Without the macro: `O_INSTRUCTION`=0xFFFF_FFFF and PC advances to 12.
- **Asynchronous reset mid-run:** assert `RESET` between clock edges at PC=0x20.
  - Required: `O_PC`=0 before the next edge.
  - Required: memory contents are unchanged after reset.
